// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED status sequencer: FSM states,
// LED bit positions and the PIO register map.
package led_seq_pkg;

  localparam int LED_W    = 8;
  localparam int ERR_BIT  = 7;
  localparam int HB_BIT   = 6;
  localparam int BUSY_BIT = 5;
  localparam int IDX_LSB  = 0;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } seq_state_e;

  // The PIO data register is 32 bits wide; only the low LED_W bits drive LEDs.
  function automatic logic [31:0] pio_word(input logic [LED_W-1:0] val);
    return {{(32-LED_W){1'b0}}, val};
  endfunction

endpackage

// File: rtl/led_status_sequencer_if.sv
// Avalon-MM bus between the LED sequencer (master) and the LED PIO (slave).
interface led_status_sequencer_if;

  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata
  );

  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata
  );

endinterface

// File: rtl/led_hb_div.sv
// Heartbeat generator: hb_bit toggles every HB_DIV cycles while hb_en is high,
// and is held at 0 (with its counter) while hb_en is low.
module led_hb_div #(
  parameter int HB_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic hb_en,
  output logic hb_bit
);

  localparam int CNT_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HB_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hb_q, hb_d;

  always_comb begin
    cnt_d = cnt_q;
    hb_d  = hb_q;
    if (!hb_en) begin
      cnt_d = '0;
      hb_d  = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      hb_d  = ~hb_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hb_q  <= hb_d;
    end
  end

  assign hb_bit = hb_q;

endmodule

// File: rtl/led_status_sequencer.sv
// Merges layer progress, error and heartbeat into a shadow LED pattern and
// pushes each change to the LED PIO with a write followed by a read-back verify.
module led_status_sequencer
  import led_seq_pkg::*;
#(
  parameter int HB_DIV    = 25000000,
  parameter int MAX_RETRY = 3,
  parameter int IDX_W     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    layer_start,
  input  logic                    layer_done,
  input  logic [IDX_W-1:0]        layer_idx,
  input  logic                    err_in,
  input  logic                    err_clr,
  input  logic                    hb_en,
  led_status_sequencer_if.master  pio,
  output logic                    seq_busy,
  output logic                    fault
);

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hb_bit;
  logic [LED_W-1:0] shadow;
  logic             dirty;

  seq_state_e       state_q, state_d;
  logic [LED_W-1:0] wr_val_q, wr_val_d;
  logic [LED_W-1:0] committed_q, committed_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       retry_next;
  logic             fault_q, fault_d;
  logic             seq_busy_q, seq_busy_d;
  logic             cs_q, cs_d;
  logic             write_n_q, write_n_d;
  logic [1:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  led_hb_div #(.HB_DIV(HB_DIV)) u_hb_div (
    .clk    (clk),
    .reset  (reset),
    .hb_en  (hb_en),
    .hb_bit (hb_bit)
  );

  // Set requests win over clears so a same-cycle error or layer start is never lost.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_in)  err_d = 1'b1;
    busy_d = busy_q;
    if (layer_done)  busy_d = 1'b0;
    if (layer_start) busy_d = 1'b1;
    idx_d = layer_done ? layer_idx : idx_q;
  end

  always_comb begin
    shadow            = '0;
    shadow[ERR_BIT]   = err_q;
    shadow[HB_BIT]    = hb_bit;
    shadow[BUSY_BIT]  = busy_q;
    shadow[IDX_LSB +: IDX_W] = idx_q;
  end

  assign dirty      = (shadow != committed_q);
  assign retry_next = retry_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    wr_val_d    = wr_val_q;
    committed_d = committed_q;
    retry_d     = retry_q;
    fault_d     = fault_q;
    seq_busy_d  = 1'b0;
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    addr_d      = PIO_DATA_ADDR;
    wdata_d     = '0;
    if (err_clr) fault_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dirty) begin
          wr_val_d   = shadow;
          retry_d    = '0;
          state_d    = WRITE;
          seq_busy_d = 1'b1;
          cs_d       = 1'b1;
          write_n_d  = 1'b0;
          wdata_d    = pio_word(shadow);
        end
      end
      WRITE: begin
        state_d    = READ;
        seq_busy_d = 1'b1;
        cs_d       = 1'b1;
      end
      READ: begin
        if (pio.pio_readdata[LED_W-1:0] == wr_val_q) begin
          committed_d = wr_val_q;
          state_d     = IDLE;
        end else begin
          retry_d = retry_next;
          if (retry_next < RETRY_LIMIT) begin
            state_d    = WRITE;
            seq_busy_d = 1'b1;
            cs_d       = 1'b1;
            write_n_d  = 1'b0;
            wdata_d    = pio_word(wr_val_q);
          end else begin
            // Give up on this pattern but mark it committed so we do not livelock.
            fault_d     = 1'b1;
            committed_d = wr_val_q;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      state_q     <= IDLE;
      wr_val_q    <= '0;
      committed_q <= '0;
      retry_q     <= '0;
      fault_q     <= 1'b0;
      seq_busy_q  <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      addr_q      <= PIO_DATA_ADDR;
      wdata_q     <= '0;
    end else begin
      err_q       <= err_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      wr_val_q    <= wr_val_d;
      committed_q <= committed_d;
      retry_q     <= retry_d;
      fault_q     <= fault_d;
      seq_busy_q  <= seq_busy_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign pio.pio_chipselect = cs_q;
  assign pio.pio_write_n    = write_n_q;
  assign pio.pio_address    = addr_q;
  assign pio.pio_writedata  = wdata_q;
  assign seq_busy           = seq_busy_q;
  assign fault              = fault_q;

endmodule

// File: doc/led_status_sequencer.md
Name: led_status_sequencer

Overview:
- Avalon-MM master that owns the 8-bit LED PIO slave in the layer_controller system and is the only agent that writes it.
- Merges layer progress events (start/done/index), an error flag and a heartbeat into one shadow LED pattern.
- Pushes every change of that pattern to the PIO with a write, then a read-back verify, retrying on mismatch.
- Sits between the FFNN layer sequencing logic and the PIO.

Parameters:
HB_DIV, 25000000, heartbeat half-period in clk cycles (>=2)
MAX_RETRY, 3, write+verify attempts per pattern before fault is declared (1..15)
IDX_W, 5, width of layer index shown on LEDs (fixed so IDX_W+3 = 8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
layer_start  in  1  one-cycle pulse: a layer begins computing
layer_done  in  1  one-cycle pulse: a layer finished
layer_idx  in  IDX_W  index of finishing layer, valid with layer_done
err_in  in  1  one-cycle pulse: datapath error
err_clr  in  1  clears sticky error bit
hb_en  in  1  heartbeat enable; 0 holds heartbeat bit at 0
pio_address  out  2  Avalon address to PIO
pio_chipselect  out  1  Avalon chipselect
pio_write_n  out  1  Avalon active-low write
pio_writedata  out  32  Avalon write data
pio_readdata  in  32  Avalon read data (combinational from slave, zero wait)
seq_busy  out  1  FSM not in IDLE
fault  out  1  sticky: verify failed MAX_RETRY times; cleared by err_clr

Behaviour:
- Single clock domain. Reset is asynchronous, active-high. All registers clear on reset assertion.
- Reset values: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, seq_busy=0, fault=0; shadow=0, committed=0, FSM=IDLE.
- Shadow pattern bits:
  - [7] err sticky: set by err_in; cleared by err_clr; set wins if both in the same cycle.
  - [6] heartbeat.
  - [5] busy: set by layer_start, cleared by layer_done; start+done in the same cycle leaves busy=1.
  - [4:0] layer_idx latched on layer_done.
- Heartbeat: counter 0..HB_DIV-1. Bit[6] toggles on each wrap. When hb_en=0, the counter and the bit are held at 0.
- The shadow updates every cycle regardless of FSM state. dirty = (shadow != committed).
- FSM states and transitions:
  - IDLE: if dirty, latch wr_val=shadow, clear retry_cnt, go to WRITE.
  - WRITE (1 cycle): chipselect=1, write_n=0, address=0, writedata={24'b0, wr_val}. Go to READ.
  - READ (1 cycle): chipselect=1, write_n=1, address=0. Sample pio_readdata[7:0] at the end of the cycle.
    - Match: committed=wr_val, go to IDLE.
    - Mismatch: retry_cnt+1. If the new count is below MAX_RETRY, go to WRITE (same wr_val).
    - Otherwise set fault, committed=wr_val (prevents livelock), go to IDLE.
- Outside WRITE/READ: chipselect=0, write_n=1, writedata=0, address=0.
- Latency: an event registered at edge E makes dirty true in the following cycle. The WRITE strobe is visible in the cycle after edge E+1. Minimum 3 cycles per update (IDLE, WRITE, READ).
- Shadow changes during WRITE/READ are not merged into the in-flight wr_val. They are picked up on the next IDLE pass; no update is lost, intermediate values may be skipped.
- Reset mid-transaction aborts immediately. Bus outputs return to idle values asynchronously and no partial retry is resumed.
- Retry bookkeeping:
  - err_clr also clears fault; it does not restart a transaction.
  - A fault during retries does not block later updates.
  - retry_cnt is 4 bits wide.

Decomposition:
- Package led_seq_pkg:
  - state enum {IDLE, WRITE, READ}
  - LED bit-position constants (ERR_BIT=7, HB_BIT=6, BUSY_BIT=5, IDX_LSB=0)
  - LED_W=8
  - PIO_DATA_ADDR=2'd0
- One sub-module, led_hb_div: heartbeat counter and toggle with HB_DIV and hb_en.
- Everything else lives in the top: shadow register, FSM, Avalon drive.

Test Plan:
- Reset released, hb_en=0, PIO model echoes data → no chipselect for 100 cycles; all outputs at reset values.
- layer_start pulse → WRITE with writedata=0x20, then READ; committed=0x20; seq_busy high exactly 2 cycles.
- layer_done with layer_idx=5'd9 plus err_in in the same cycle → single write 0x89; err_clr later → write 0x09.
- HB_DIV=4, hb_en=1, idle datapath → writes alternate 0x40/0x00 every 4 cycles; toggle period matches.
- PIO model forces readdata[7:0]=0x00 with MAX_RETRY=3, layer_start → 3 WRITE/READ pairs, then fault=1; next event still issues a write.
- Reset asserted during WRITE of 0x20 → chipselect drops asynchronously; after release, shadow=0 and no write occurs.
